three_operand_adder_pipe: RTL and testbench



---
 rtl/toa_pkg.sv | 33 +++
 rtl/toa_prefix_adder.sv | 40 ++++
 rtl/three_operand_adder_pipe.sv | 113 +++++++++++
 tb/tb_three_operand_adder_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toa_pkg.sv
// Shared types and helpers for the three-operand pipelined adder: prefix-cell
// generate/propagate pair, the grey/black cell operators and the result width.
package toa_pkg;

  localparam int TOA_LATENCY = 2;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int toa_out_w(input int width);
    return width + 2;
  endfunction

  // Black cell: merges a high group with the adjacent lower group.
  function automatic gp_t gp_black(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Grey cell: the lower group already reaches bit 0, so only g matters
  // downstream and p is carried through unchanged.
  function automatic gp_t gp_grey(input gp_t hi, input logic lo_g);
    gp_t r;
    r.g = hi.g | (hi.p & lo_g);
    r.p = hi.p;
    return r;
  endfunction

endpackage

// File: rtl/toa_prefix_adder.sv
// Combinational N-bit Kogge-Stone adder: s = x + y modulo 2^N, built from a
// log2(N)-level tree of grey/black cells.
module toa_prefix_adder
  import toa_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);

  localparam int LEVELS = $clog2(N);

  gp_t gp [0:LEVELS][N-1:0];

  for (genvar i = 0; i < N; i++) begin : g_init
    assign gp[0][i] = '{g: x[i] & y[i], p: x[i] ^ y[i]};
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int D = 1 << l;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign gp[l+1][i] = gp[l][i];
      end else if (i < 2 * D) begin : g_grey
        assign gp[l+1][i] = gp_grey(gp[l][i], gp[l][i-D].g);
      end else begin : g_black
        assign gp[l+1][i] = gp_black(gp[l][i], gp[l][i-D]);
      end
    end
  end

  // Final group generate at bit i-1 is the carry into bit i.
  assign s[0] = gp[0][0].p;
  for (genvar i = 1; i < N; i++) begin : g_sum
    assign s[i] = gp[0][i].p ^ gp[LEVELS][i-1].g;
  end

endmodule

// File: rtl/three_operand_adder_pipe.sv
// Two-stage valid/ready pipelined adder S = a + b + c + cin (carry-save row,
// then prefix add). Define TOA_SIGNED_EN for two's-complement operands.
module three_operand_adder_pipe
  import toa_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int OUT_W = toa_out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] S,
  output logic             Cout
);

  function automatic logic [OUT_W-1:0] ext(input logic [WIDTH-1:0] x);
`ifdef TOA_SIGNED_EN
    return {{(OUT_W-WIDTH){x[WIDTH-1]}}, x};
`else
    return {{(OUT_W-WIDTH){1'b0}}, x};
`endif
  endfunction

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] sv_q, sv_d;
  logic [OUT_W-1:0] cv_q, cv_d;
  logic [OUT_W-1:0] s_q,  s_d;

  logic [OUT_W-1:0] a_x, b_x, c_x;
  logic [OUT_W-1:0] row_s, row_c;
  logic [OUT_W-2:0] row_maj;
  logic [OUT_W-1:0] sum_w;
  logic             en1, en2, in_fire;

  assign in_ready = ~v1_q | ~v2_q | out_ready;
  assign en2      = v1_q & (~v2_q | out_ready);
  assign en1      = ~v1_q | en2;
  assign in_fire  = in_valid & in_ready;

  // The row spans OUT_W bits so a sign extension passes straight through it;
  // the carry out of the top bit is dropped because the exact sum fits.
  assign a_x     = ext(a);
  assign b_x     = ext(b);
  assign c_x     = ext(c);
  assign row_s   = a_x ^ b_x ^ c_x;
  assign row_maj = (a_x[OUT_W-2:0] & b_x[OUT_W-2:0]) |
                   (a_x[OUT_W-2:0] & c_x[OUT_W-2:0]) |
                   (b_x[OUT_W-2:0] & c_x[OUT_W-2:0]);
  assign row_c   = {row_maj, cin};

  toa_prefix_adder #(
    .N (OUT_W)
  ) u_prefix (
    .x (sv_q),
    .y (cv_q),
    .s (sum_w)
  );

  always_comb begin
    // NOTE: each _d starts from its hold value, so no branch can infer a latch.
    v1_d = v1_q;
    v2_d = v2_q;
    sv_d = sv_q;
    cv_d = cv_q;
    s_d  = s_q;

    if (en1) begin
      v1_d = in_fire;
      if (in_fire) begin
        sv_d = row_s;
        cv_d = row_c;
      end
    end

    if (en2) begin
      v2_d = 1'b1;
      s_d  = sum_w;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well, so S and Cout read 0 in reset.
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sv_q <= '0;
      cv_q <= '0;
      s_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the pre-edge values.
      v1_q <= v1_d;
      v2_q <= v2_d;
      sv_q <= sv_d;
      cv_q <= cv_d;
      s_q  <= s_d;
    end
  end

  assign out_valid = v2_q;
  assign S         = s_q;
  assign Cout      = s_q[OUT_W-1];

endmodule

// File: tb/tb_three_operand_adder_pipe.sv
// Self-checking bench: WIDTH=32 instance against a scoreboarded integer model,
// plus a WIDTH=4 instance for the directed latency/limit vectors.
module tb_three_operand_adder_pipe;
  import toa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout32;
  logic [31:0] a, b, c;
  logic [33:0] s32;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
  logic [3:0] a4, b4, c4;
  logic [5:0] s4;

  three_operand_adder_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .S(s32), .Cout(cout32)
  );

  three_operand_adder_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c(c4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .S(s4), .Cout(cout4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  string cur_tag = "none";

  typedef struct {
    logic [33:0] exp;
    string       tag;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Exact integer sum, truncated to the 34-bit result field.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic ci);
    longint sx, sy, sz, sum;
`ifdef TOA_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sz = longint'($signed(z));
`else
    sx = longint'({32'b0, x});
    sy = longint'({32'b0, y});
    sz = longint'({32'b0, z});
`endif
    sum = sx + sy + sz + longint'(ci);
    return sum[33:0];
  endfunction

  // Scoreboard: push on input transfer, compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          check(e.tag, s32, e.exp);
          check({e.tag, "_cout"}, cout32, e.exp[33]);
          n_out++;
        end
      end
      if (in_valid && in_ready) q.push_back('{model32(a, b, c, cin), cur_tag});
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic ci);
    bit fired = 0;
    a = x; b = y; c = z; cin = ci; in_valid = 1'b1;
    for (int k = 0; k < 50 && !fired; k++) begin
      fired = in_ready;
      @(posedge clk); #1;
    end
    if (!fired) check("send_timeout", 0, 1);
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                      input logic ci, input logic [5:0] exp_s, input string tag);
    @(posedge clk); #1;
    a4 = x; b4 = y; c4 = z; cin4 = ci; in_valid4 = 1'b1;
    check({tag, "_in_ready"}, in_ready4, 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check({tag, "_early"}, out_valid4, 0);
    repeat (TOA_LATENCY - 1) @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid4, 1);
    check({tag, "_S"}, s4, exp_s);
    check({tag, "_cout"}, cout4, exp_s[5]);
    @(posedge clk); #1;
    check({tag, "_drained"}, out_valid4, 0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] exp1;
    int base;
    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; c = 0; cin = 0; out_ready = 1;
    in_valid4 = 0; a4 = 0; b4 = 0; c4 = 0; cin4 = 0; out_ready4 = 1;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_S", s32, 0);
    check("reset_cout", cout32, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid4", out_valid4, 0);
    #10 rst_n = 1'b1;

    // Directed WIDTH=4 limits and latency
`ifdef TOA_SIGNED_EN
    run4(4'h8, 4'h8, 4'h8, 1'b0, 6'b101000, "s4_min");
    run4(4'h7, 4'h7, 4'h7, 1'b1, 6'd22, "s4_max");
    run4(4'hF, 4'h2, 4'h1, 1'b0, 6'd2, "s4_mix");
`else
    run4(4'hF, 4'hF, 4'hF, 1'b1, 6'd46, "u4_max");
    run4(4'h9, 4'h3, 4'h5, 1'b0, 6'd17, "u4_mid");
    run4(4'h0, 4'h0, 4'h0, 1'b0, 6'd0, "u4_zero");
`endif

    // Back-to-back streaming
    @(posedge clk); #1;
    cur_tag = "stream";
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      check("stream_in_ready", in_ready, 1);
      if (i >= TOA_LATENCY) check("stream_back2back", out_valid, 1);
      send($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", n_out - base, 100);

    // Width-32 corners
    cur_tag = "zero_cin";
    send(32'h0, 32'h0, 32'h0, 1'b1);
    cur_tag = "all_ones";
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: result 1 held, operand 2 accepted, operand 3 stalled
    cur_tag = "bp";
    out_ready = 0;
    exp1 = model32(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b1);
    send(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b1);
    send(32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_0000, 1'b0);
    a = 32'h5555_5555; b = 32'hAAAA_AAAA; c = 32'h3333_3333; cin = 1; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid_held", out_valid, 1);
      check("bp_S_held", s32, exp1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send(32'h5555_5555, 32'hAAAA_AAAA, 32'h3333_3333, 1'b1);
    in_valid = 0;
    check("bp_res2_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_res3_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_empty", out_valid, 0);
    check("bp_drained", q.size(), 0);

    // Asynchronous reset with both stages full
    cur_tag = "rst";
    out_ready = 0;
    send($urandom, $urandom, $urandom, 1'b1);
    send($urandom, $urandom, $urandom, 1'b1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_S", s32, 0);
    check("rst_cout", cout32, 0);
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check("rst_no_stale", out_valid, 0);
      @(posedge clk); #1;
    end

    // Random valid/ready traffic
    cur_tag = "rand";
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick32(); b = pick32(); c = pick32();
      cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    check("final_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
